// File: rtl/asyn_fifo_pkg.sv
// asyn_fifo shared constants and helpers.
// Provides the default geometry and the address-width function.
package asyn_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int addr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < depth) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/asyn_fifo_ram.sv
// asyn_fifo storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module asyn_fifo_ram
    import asyn_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/asyn_fifo.sv
// asyn_fifo: single-clock FIFO with wrap-bit pointers.
// Define ASYN_FIFO_COUNT_EN to expose the occupancy count port.
module asyn_fifo
    import asyn_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic             rinc,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             wfull,
    output logic             rempty
`ifdef ASYN_FIFO_COUNT_EN
    ,
    output logic [AW:0]      count
`endif
);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        wen;
    logic        ren;

    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);

    // Each request is gated by the flag seen before the edge.
    assign wen = winc && !wfull;
    assign ren = rinc && !rempty;

`ifdef ASYN_FIFO_COUNT_EN
    assign count = wptr - rptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wen) begin
                wptr <= wptr + 1'b1;
            end
            if (ren) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    asyn_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wen),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .re    (ren),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_asyn_fifo.sv
// tb_asyn_fifo: randomized bench against a queue reference model.
// Count checks are active when ASYN_FIFO_COUNT_EN is defined.
module tb_asyn_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             clk_run;
    logic             rst;
    logic             winc;
    logic             rinc;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             wfull;
    logic             rempty;
`ifdef ASYN_FIFO_COUNT_EN
    logic [AW:0]      count;
`endif

    asyn_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .rinc   (rinc),
        .wdata  (wdata),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
`ifdef ASYN_FIFO_COUNT_EN
        ,
        .count  (count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    int n_tests;
    int n_fail;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".rempty"}, 32'(rempty), 32'(q.size() == 0));
        check({tag, ".wfull"}, 32'(wfull), 32'(q.size() == DEPTH));
        check({tag, ".rdata"}, 32'(rdata), 32'(last_rd));
`ifdef ASYN_FIFO_COUNT_EN
        check({tag, ".count"}, 32'(count), 32'(q.size()));
`endif
    endtask

    // One clock: drive, apply model rules at the edge, then compare.
    task automatic step(input logic w, input logic r,
                        input logic [WIDTH-1:0] d, input string tag);
        bit can_w;
        bit can_r;
        winc  = w;
        rinc  = r;
        wdata = d;
        can_w = q.size() < DEPTH;
        can_r = q.size() > 0;
        @(posedge clk);
        if (r && can_r) last_rd = q.pop_front();
        if (w && can_w) q.push_back(d);
        #1;
        check_state(tag);
    endtask

    task automatic async_reset();
        @(negedge clk);
        clk_run = 1'b0;
        winc    = 1'b0;
        rinc    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        last_rd = '0;
        check_state("async_rst");
        #19;
        rst = 1'b0;
        #1;
        check_state("rst_release");
        clk_run = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk_run = 1'b1;
        rst     = 1'b1;
        winc    = 1'b0;
        rinc    = 1'b0;
        wdata   = '0;
        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Partial traffic, then reset with the clock stopped.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom), "pre");
        step(1'b0, 1'b1, '0, "pre_rd");
        async_reset();

        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 8'($urandom_range(29)), "burst_wr");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "burst_rd");

        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 8'($urandom), "fill_wr");
        step(1'b1, 1'b0, 8'hA5, "fill_over");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "fill_rd");

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "underflow");
        step(1'b1, 1'b0, 8'h3C, "post_uf_wr");
        step(1'b0, 1'b1, '0, "post_uf_rd");

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "sim_pre");
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 8'($urandom), "sim_mid");
        while (q.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom), "sim_fill");
        step(1'b1, 1'b1, 8'h5A, "sim_full");
        step(1'b0, 1'b0, '0, "sim_after");
        while (q.size() > 0) step(1'b0, 1'b1, '0, "sim_drain");
        step(1'b1, 1'b1, 8'h77, "sim_empty");
        step(1'b0, 1'b1, '0, "sim_empty_rd");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++)
                step(1'b1, 1'b0, 8'($urandom), "wrap_wr");
            for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "wrap_rd");
        end

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(1)), 1'($urandom_range(1)),
                 8'($urandom), "random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
